mux_chan_sched: RTL and testbench

- Round-robin channel scheduler sitting directly upstream of the 4:1 gate-level select mux.
- Arbitrates four source requests and drives the mux select pair (s1,s0).
- Holds each selection stable for a bounded number of accepted beats, then hands over to the next requester.
- Provides a valid/ready handshake toward the sink that consumes the mux output.

---
 rtl/mux_chan_sched_pkg.sv | 17 +
 rtl/mux_chan_sched_if.sv | 23 ++
 rtl/mux_chan_sched_rr_pick.sv | 26 ++
 rtl/mux_chan_sched.sv | 117 +++++++++++
 tb/tb_mux_chan_sched.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mux_chan_sched_pkg.sv
// Shared types and constants for the round-robin mux channel scheduler.
package mux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_chan_sched_if.sv
// Request/select bundle between the sources, the scheduler and the mux sink.
interface mux_chan_sched_if;
    import mux_sched_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              sink_ready;
    logic              s0;
    logic              s1;
    logic              sel_valid;
    logic [NUM_CH-1:0] grant;
    logic              done;

    modport master (
        output req, sink_ready,
        input  s0, s1, sel_valid, grant, done
    );

    modport slave (
        input  req, sink_ready,
        output s0, s1, sel_valid, grant, done
    );

endinterface

// File: rtl/mux_chan_sched_rr_pick.sv
// Combinational circular-priority picker: first set request after ptr.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    always_comb begin
        logic [CH_W-1:0] cand;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Offsets 1..NUM_CH wrap modulo 4, so ptr itself is checked last.
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = ptr + CH_W'(i);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_chan_sched.sv
// Round-robin scheduler driving the 4:1 mux select with a bounded dwell per grant.
module mux_chan_sched
    import mux_sched_pkg::*;
#(
    parameter int DWELL = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    mux_chan_sched_if.slave  bus
);

    localparam int CNT_W = $clog2(DWELL + 1);

    if (DWELL < 1) begin : g_dwell_chk
        $error("mux_chan_sched: DWELL must be at least 1");
    end

    state_t            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic [CNT_W-1:0]  cnt_inc;
    logic              drop;
    logic              beat;
    logic              release_w;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A dropped request wins over a beat, so no beat is counted on that edge.
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign drop      = !bus.req[sel_q];
    assign beat      = !drop && bus.sink_ready;
    assign release_w = (state_q == GRANT) && (drop || (beat && cnt_inc == CNT_W'(DWELL)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            grant_q <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any)  state_d = GRANT;
            GRANT:   if (release_w) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                vld_d   = 1'b0;
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (beat) cnt_d = cnt_inc;
                // Select lines are left as-is on release; only valid/grant drop.
                if (release_w) begin
                    vld_d   = 1'b0;
                    grant_d = '0;
                    done_d  = 1'b1;
                    ptr_d   = sel_q;
                end
            end
            default: begin
                vld_d   = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    assign bus.s0        = sel_q[0];
    assign bus.s1        = sel_q[1];
    assign bus.sel_valid = vld_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_chan_sched.sv
// Scoreboard bench for mux_chan_sched: a behavioural model queues expected outputs per edge.
module tb_mux_chan_sched;
    import mux_sched_pkg::*;

    localparam int DWELL = 3;

    typedef struct packed {
        logic [1:0] sel;
        logic       vld;
        logic [3:0] grant;
        logic       done;
    } obs_t;

    logic clk;
    logic rst_n;
    mux_chan_sched_if bus();

    mux_chan_sched #(.DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    obs_t  mon_exp;
    obs_t  mon_got;
    int    errors = 0;
    int    checks = 0;
    int    edge_no = 0;
    string phase = "reset";

    // Reference: who (if anyone) owns the mux, how many beats they have had, who was served last.
    bit m_busy;
    int m_ch;
    int m_beats;
    int m_last;
    int m_sel;
    bit m_done;

    function automatic void model(input bit rn, input logic [3:0] r, input bit rdy);
        m_done = 1'b0;
        if (!rn) begin
            m_busy = 1'b0; m_ch = 0; m_beats = 0; m_last = 3; m_sel = 0;
            return;
        end
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (r[c]) begin
                    m_busy = 1'b1; m_ch = c; m_sel = c; m_beats = 0;
                    break;
                end
            end
        end else begin
            bit rel;
            rel = 1'b0;
            if (!r[m_ch]) rel = 1'b1;
            else if (rdy) begin
                m_beats++;
                if (m_beats == DWELL) rel = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0; m_done = 1'b1; m_last = m_ch;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.sel   = 2'(m_sel);
        o.vld   = m_busy;
        o.grant = m_busy ? (4'b0001 << m_ch) : 4'b0000;
        o.done  = m_done;
        return o;
    endfunction

    task automatic step(input bit rn, input logic [3:0] r, input bit rdy);
        @(negedge clk);
        rst_n          = rn;
        bus.req        = r;
        bus.sink_ready = rdy;
        model(rn, r, rdy);
        exp_q.push_back(model_obs());
    endtask

    always @(posedge clk) begin
        #1;
        edge_no++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got.sel   = {bus.s1, bus.s0};
            mon_got.vld   = bus.sel_valid;
            mon_got.grant = bus.grant;
            mon_got.done  = bus.done;
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL %s edge %0d: got sel=%0d vld=%b grant=%b done=%b, want sel=%0d vld=%b grant=%b done=%b",
                         phase, edge_no, mon_got.sel, mon_got.vld, mon_got.grant, mon_got.done,
                         mon_exp.sel, mon_exp.vld, mon_exp.grant, mon_exp.done);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        rst_n          = 1'b0;
        bus.req        = 4'b0000;
        bus.sink_ready = 1'b0;

        phase = "reset";
        repeat (2) step(1'b0, 4'b1111, 1'b1);

        phase = "round_robin";
        repeat (21) step(1'b1, 4'b1111, 1'b1);

        phase = "backpressure";
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 4'b0010, 1'(i % 2));

        phase = "req_drop";
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b1100, 1'b1);
        step(1'b1, 4'b1100, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        repeat (5) step(1'b1, 4'b1000, 1'b1);

        phase = "wrap";
        repeat (10) step(1'b1, 4'b1001, 1'b1);

        phase = "mid_reset";
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        repeat (6) step(1'b1, 4'b0011, 1'b1);

        phase = "idle_ready";
        repeat (3) step(1'b1, 4'b0000, 1'b1);

        phase = "random";
        rq = 4'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 3)] ^= 1'b1;
            step(($urandom_range(0, 79) != 0), rq, ($urandom_range(0, 2) != 0));
        end

        phase = "drain";
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
